pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It sits beside the stage registers. It generates freeze for PC/IF and the IF/ID register, and flush for the IF/ID and ID/EX registers. It also runs the multi-cycle data-memory handshake FSM that freezes the whole pipeline while the SRAM controller is busy, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: hazard detection,
// data-memory wait FSM with timeout, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_start,
    output logic             freeze_if,
    output logic             freeze_pipe,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            err_set;
    logic            start_raw, fpipe_raw;
    logic            m1_exe, m2_exe, m1_mem, m2_mem;
    logic            hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set)
                mem_error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        start_raw    = 1'b0;
        fpipe_raw    = 1'b0;
        err_set      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mem_access) begin
                    start_raw    = 1'b1;
                    fpipe_raw    = 1'b1;
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WC_W'(TIMEOUT)) begin
                    // Give up on the SRAM: release the pipe and flag it.
                    err_set      = 1'b1;
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    fpipe_raw    = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign m1_exe = id_valid & (src1 == exe_dest);
    assign m2_exe = two_src & (src2 == exe_dest);
    assign m1_mem = id_valid & (src1 == mem_dest);
    assign m2_mem = two_src & (src2 == mem_dest);

    always_comb begin
        if (forward_en)
            hazard = exe_mem_r_en & (m1_exe | m2_exe);
        else
            hazard = (exe_wb_en & (m1_exe | m2_exe))
                   | (mem_wb_en & (m1_mem | m2_mem));
    end

    // Memory freeze masks branch and hazard; they re-evaluate on release.
    always_comb begin
        mem_start   = 1'b0;
        freeze_pipe = 1'b0;
        freeze_if   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        if (!rst) begin
            mem_start   = start_raw;
            freeze_pipe = fpipe_raw;
            if (fpipe_raw) begin
                freeze_if = 1'b1;
            end else if (branch_taken) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hazard) begin
                freeze_if = 1'b1;
                flush_id  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze_if && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_if && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected output vectors are
// queued as stimulus is driven and popped at the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_en, two_src, id_valid;
    logic [3:0]  src1, src2, exe_dest, mem_dest;
    logic        exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        mem_access, mem_ready, branch_taken;
    logic        mem_start, freeze_if, freeze_pipe, flush_if, flush_id;
    logic        mem_error;
    logic [15:0] stall_cnt, flush_cnt;

    logic [4:0]  sb[$];
    logic [4:0]  got, e;
    int          vectors = 0;
    int          miss = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .forward_en(forward_en), .src1(src1), .src2(src2),
        .two_src(two_src), .id_valid(id_valid),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .mem_start(mem_start), .freeze_if(freeze_if),
        .freeze_pipe(freeze_pipe), .flush_if(flush_if),
        .flush_id(flush_id), .mem_error(mem_error),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {mem_start, freeze_if, freeze_pipe, flush_if, flush_id}
    wire [4:0] obs = {mem_start, freeze_if, freeze_pipe, flush_if, flush_id};

    task automatic clear_inputs();
        forward_en = 0; two_src = 0; id_valid = 0;
        src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        mem_access = 0; mem_ready = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mem_error !== 1'b0) begin
            miss++;
            $display("FAIL reset_state got st=%0d fl=%0d err=%b exp 0/0/0",
                     stall_cnt, flush_cnt, mem_error);
        end
        for (int i = 0; i < 4; i++) begin
            mem_access = 1'b1;
            sb.push_back(i == 0 ? 5'b11100 : 5'b01100);
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL reset_wait c%0d got=%b exp=%b", i, got, e);
            end
            if (i < 3) next_cycle();
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 5'b0 || stall_cnt !== 16'd0) begin
            miss++;
            $display("FAIL reset_async got=%b st=%0d exp=00000 st=0", obs, stall_cnt);
        end
        next_cycle();
        rst = 1'b0;
        mem_access = 1'b0;
        sb.push_back(5'b00000);
        @(negedge clk);
        got = obs; e = sb.pop_front(); vectors++;
        if (got !== e || mem_error !== 1'b0) begin
            miss++;
            $display("FAIL reset_idle got=%b err=%b exp=%b err=0", got, mem_error, e);
        end
    endtask

    task automatic test_mem_handshake();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            mem_access = (i <= 4);
            mem_ready  = (i == 4) || (i == 5);
            case (i)
                0:       sb.push_back(5'b11100);
                1, 2, 3: sb.push_back(5'b01100);
                default: sb.push_back(5'b00000);
            endcase
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL mem_hs c%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
        vectors++;
        if (stall_cnt !== 16'd4 || mem_error !== 1'b0) begin
            miss++;
            $display("FAIL mem_hs_cnt got st=%0d err=%b exp st=4 err=0",
                     stall_cnt, mem_error);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_access = (i < 4);
            mem_ready  = (i == 1) || (i == 3);
            sb.push_back((i == 0 || i == 2) ? 5'b11100 : 5'b00000);
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL b2b c%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
        vectors++;
        if (stall_cnt !== 16'd2) begin
            miss++;
            $display("FAIL b2b_cnt got=%0d exp=2", stall_cnt);
        end
    endtask

    task automatic test_raw_noforward();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            src1 = 4'd3;
            id_valid = 1'b1;
            case (i)
                0: begin exe_dest = 4'd3; exe_wb_en = 1; sb.push_back(5'b01001); end
                1: begin exe_dest = 4'd3; exe_wb_en = 1; id_valid = 0;
                         sb.push_back(5'b00000); end
                2: begin mem_dest = 4'd3; mem_wb_en = 1; sb.push_back(5'b01001); end
                3: begin mem_dest = 4'd4; mem_wb_en = 1; sb.push_back(5'b00000); end
                default: begin mem_dest = 4'd3; mem_wb_en = 1; forward_en = 1;
                               sb.push_back(5'b00000); end
            endcase
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL raw_nofwd v%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
        vectors++;
        if (stall_cnt !== 16'd2) begin
            miss++;
            $display("FAIL raw_nofwd_cnt got=%0d exp=2", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            forward_en = 1'b1;
            exe_dest = 4'd5;
            exe_wb_en = 1'b1;
            case (i)
                0: begin two_src = 1; src2 = 4'd5; exe_mem_r_en = 1;
                         sb.push_back(5'b01001); end
                1: begin two_src = 1; src2 = 4'd5; sb.push_back(5'b00000); end
                2: begin src2 = 4'd5; exe_mem_r_en = 1; sb.push_back(5'b00000); end
                default: begin id_valid = 1; src1 = 4'd5; exe_mem_r_en = 1;
                               sb.push_back(5'b01001); end
            endcase
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL load_use v%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            if (i < 3) begin
                branch_taken = 1; id_valid = 1; src1 = 4'd3;
                exe_dest = 4'd3; exe_wb_en = 1;
            end
            mem_access = (i == 1) || (i == 2);
            mem_ready  = (i == 2);
            case (i)
                0, 2:    sb.push_back(5'b00011);
                1:       sb.push_back(5'b11100);
                default: sb.push_back(5'b00000);
            endcase
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL branch v%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
        vectors++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd1) begin
            miss++;
            $display("FAIL branch_cnt got fl=%0d st=%0d exp fl=2 st=1",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_access = (i <= 8);
            if (i == 0)     sb.push_back(5'b11100);
            else if (i < 8) sb.push_back(5'b01100);
            else            sb.push_back(5'b00000);
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL timeout c%0d got=%b exp=%b", i, got, e);
            end
            if (i == 8) begin
                vectors++;
                if (mem_error !== 1'b0) begin
                    miss++;
                    $display("FAIL timeout_early got=%b exp=0", mem_error);
                end
            end
            next_cycle();
        end
        vectors++;
        if (mem_error !== 1'b1 || stall_cnt !== 16'd8) begin
            miss++;
            $display("FAIL timeout_err got err=%b st=%0d exp err=1 st=8",
                     mem_error, stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            mem_access = (i < 2);
            mem_ready  = (i == 1);
            sb.push_back(i == 0 ? 5'b11100 : 5'b00000);
            @(negedge clk);
            got = obs; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miss++;
                $display("FAIL timeout_after c%0d got=%b exp=%b", i, got, e);
            end
            next_cycle();
        end
        vectors++;
        if (mem_error !== 1'b1) begin
            miss++;
            $display("FAIL timeout_sticky got=%b exp=1", mem_error);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid = 1; src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1;
        repeat (65534) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin
            miss++;
            $display("FAIL sat_pre got=%h exp=fffe", stall_cnt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miss++;
            $display("FAIL sat_hit got=%h exp=ffff", stall_cnt);
        end
        repeat (4465) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miss++;
            $display("FAIL sat_hold got=%h exp=ffff", stall_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_mem_handshake();
        test_back_to_back();
        test_raw_noforward();
        test_load_use();
        test_branch();
        test_timeout();
        test_saturation();
        vectors++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
